// File: rtl/ddr3_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_traffic_checker
// Description : Board bring-up traffic generator for the DDR3 controller.
//               Writes NUM_WORDS words of a selectable pattern from a base
//               address, reads the range back, compares against a regenerated
//               copy and reports pass/fail, error count, first failing address
//               and a read-data timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_traffic_checker #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int NUM_WORDS             = 256,
  parameter int ERR_CNT_WIDTH         = 16,
  parameter int TIMEOUT_CYCLES        = 4096,
  parameter int LFSR_SEED             = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [1:0]                                        mode,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_address,
  input  logic                                              cmd_ready,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] user_address,
  output logic [DQ_BITWIDTH-1:0]                            user_wdata,
  input  logic                                              rd_valid,
  input  logic [DQ_BITWIDTH-1:0]                            rd_data,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic                                              timeout,
  output logic [ERR_CNT_WIDTH-1:0]                          error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int DQ = DQ_BITWIDTH;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int OW = $clog2(NUM_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] c_LAST_IDX     = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] c_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DQ-1:0] c_SEED         = DQ'(LFSR_SEED);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Maximal-length Fibonacci tap masks (bit n-1 set for polynomial term x^n).
  function automatic logic [DQ-1:0] f_taps();
    case (DQ)
      8:       return DQ'(64'h0000_0000_0000_00B8);
      16:      return DQ'(64'h0000_0000_0000_D008);
      32:      return DQ'(64'h0000_0000_8020_0003);
      64:      return DQ'(64'hD800_0000_0000_0000);
      default: return DQ'(64'd3 << (DQ - 2));
    endcase
  endfunction

  // 0x55.. checkerboard constant, independent of data width.
  function automatic logic [DQ-1:0] f_check_even();
    logic [DQ-1:0] p;
    for (int b = 0; b < DQ; b++) p[b] = ((b % 2) == 0) ? 1'b1 : 1'b0;
    return p;
  endfunction

  localparam logic [DQ-1:0] c_TAPS       = f_taps();
  localparam logic [DQ-1:0] c_CHECK_EVEN = f_check_even();

  // Pattern word from generator state; the count register doubles as i mod 2^DQ.
  function automatic logic [DQ-1:0] f_pattern(input logic [1:0] m, input logic [DQ-1:0] cnt,
                                              input logic [DQ-1:0] walk, input logic [DQ-1:0] lfsr);
    case (m)
      2'd0:    return cnt;
      2'd1:    return walk;
      2'd2:    return lfsr;
      default: return cnt[0] ? ~c_CHECK_EVEN : c_CHECK_EVEN;
    endcase
  endfunction

  function automatic logic [DQ-1:0] f_lfsr_step(input logic [DQ-1:0] s);
    return {s[DQ-2:0], ^(s & c_TAPS)};
  endfunction

  logic [2:0]               r_state;
  logic [2:0]               w_next_state;
  logic [1:0]               r_mode;
  logic [AW-1:0]            r_base;
  logic [IW-1:0]            r_idx;
  logic [DQ-1:0]            r_wr_count, r_wr_walk, r_wr_lfsr;
  logic [IW-1:0]            r_chk_idx;
  logic [DQ-1:0]            r_chk_count, r_chk_walk, r_chk_lfsr;
  logic [OW-1:0]            r_outstanding;
  logic [TW-1:0]            r_to_cnt;
  logic                     r_timeout;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [AW-1:0]            r_first_addr;
  logic                     r_first_seen;

  logic w_start_ok, w_wr_acc, w_rd_acc, w_last, w_rd_window;
  logic w_resp, w_spurious, w_check, w_mismatch, w_to_hit;
  logic [DQ-1:0] w_exp_data;

  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_wr_acc    = (r_state == S_WRITE) & cmd_ready;
  assign w_rd_acc    = (r_state == S_READ) & cmd_ready;
  assign w_last      = (r_idx == c_LAST_IDX);
  assign w_rd_window = (r_state == S_READ) | (r_state == S_DRAIN);
  assign w_resp      = rd_valid & w_rd_window;
  // A response with nothing outstanding cannot belong to any request.
  assign w_spurious  = w_resp & (r_outstanding == '0);
  assign w_check     = w_resp & ~w_spurious;
  assign w_exp_data  = f_pattern(r_mode, r_chk_count, r_chk_walk, r_chk_lfsr);
  assign w_mismatch  = w_check & (rd_data != w_exp_data);
  assign w_to_hit    = w_rd_window & (r_outstanding != '0) & ~w_resp & (r_to_cnt == c_TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; a timeout preempts normal progress through READ/DRAIN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_WRITE;
      S_WRITE: if (w_wr_acc && w_last) w_next_state = S_READ;
      S_READ: begin
        if (w_to_hit)                w_next_state = S_DONE;
        else if (w_rd_acc && w_last) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_to_hit || (r_outstanding == '0)) w_next_state = S_DONE;
      end
      S_DONE:  if (start) w_next_state = S_WRITE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; request fields are zero whenever no request is up.
  always_comb begin
    write_enable        = (r_state == S_WRITE);
    read_enable         = (r_state == S_READ);
    user_address        = '0;
    user_wdata          = '0;
    busy                = (r_state == S_WRITE) | (r_state == S_READ) | (r_state == S_DRAIN);
    done                = (r_state == S_DONE);
    pass                = (r_state == S_DONE) & (r_err_cnt == '0) & ~r_timeout;
    timeout             = r_timeout;
    error_count         = r_err_cnt;
    first_error_address = r_first_addr;
    if ((r_state == S_WRITE) || (r_state == S_READ)) user_address = r_base + AW'(r_idx);
    if (r_state == S_WRITE) user_wdata = f_pattern(r_mode, r_wr_count, r_wr_walk, r_wr_lfsr);
  end

  // Request-side datapath: address index and write-pattern generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode     <= '0;
      r_base     <= '0;
      r_idx      <= '0;
      r_wr_count <= '0;
      r_wr_walk  <= '0;
      r_wr_lfsr  <= '0;
    end else if (w_start_ok) begin
      r_mode     <= mode;
      r_base     <= base_address;
      r_idx      <= '0;
      r_wr_count <= '0;
      r_wr_walk  <= DQ'(1);
      r_wr_lfsr  <= c_SEED;
    end else if (w_wr_acc || w_rd_acc) begin
      r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (w_wr_acc) begin
        r_wr_count <= r_wr_count + DQ'(1);
        r_wr_walk  <= {r_wr_walk[DQ-2:0], r_wr_walk[DQ-1]};
        r_wr_lfsr  <= f_lfsr_step(r_wr_lfsr);
      end
    end
  end

  // Check-side datapath: regenerated pattern, outstanding count, timeout and error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk_idx     <= '0;
      r_chk_count   <= '0;
      r_chk_walk    <= '0;
      r_chk_lfsr    <= '0;
      r_outstanding <= '0;
      r_to_cnt      <= '0;
      r_timeout     <= 1'b0;
      r_err_cnt     <= '0;
      r_first_addr  <= '0;
      r_first_seen  <= 1'b0;
    end else if (w_start_ok) begin
      r_chk_idx     <= '0;
      r_chk_count   <= '0;
      r_chk_walk    <= DQ'(1);
      r_chk_lfsr    <= c_SEED;
      r_outstanding <= '0;
      r_to_cnt      <= '0;
      r_timeout     <= 1'b0;
      r_err_cnt     <= '0;
      r_first_addr  <= '0;
      r_first_seen  <= 1'b0;
    end else begin
      if (w_check) begin
        r_chk_idx   <= r_chk_idx + IW'(1);
        r_chk_count <= r_chk_count + DQ'(1);
        r_chk_walk  <= {r_chk_walk[DQ-2:0], r_chk_walk[DQ-1]};
        r_chk_lfsr  <= f_lfsr_step(r_chk_lfsr);
      end
      if (w_rd_acc && !w_check)      r_outstanding <= r_outstanding + OW'(1);
      else if (!w_rd_acc && w_check) r_outstanding <= r_outstanding - OW'(1);
      if (w_resp)                                   r_to_cnt <= '0;
      else if (w_rd_window && r_outstanding != '0)  r_to_cnt <= r_to_cnt + TW'(1);
      if (w_to_hit) r_timeout <= 1'b1;
      if ((w_mismatch || w_spurious) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
      if (w_mismatch && !r_first_seen) begin
        r_first_addr <= r_base + AW'(r_chk_idx);
        r_first_seen <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_traffic_checker
// Description : Directed bench for ddr3_traffic_checker with a small memory
//               model (latency 5, optional random cmd_ready, fault injection).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_traffic_checker;

  localparam int AW = 18;
  localparam int DQ = 16;
  localparam int NW = 256;
  localparam int TO = 4096;

  logic          clk, reset, start, cmd_ready, rd_valid;
  logic [1:0]    mode;
  logic [AW-1:0] base_address, user_address, first_error_address;
  logic [DQ-1:0] user_wdata, rd_data;
  logic [15:0]   error_count;
  logic          write_enable, read_enable, busy, done, pass, timeout;

  ddr3_traffic_checker #(
    .ADDRESS_BITWIDTH(15), .BANK_ADDRESS_BITWIDTH(3), .DQ_BITWIDTH(DQ), .NUM_WORDS(NW),
    .ERR_CNT_WIDTH(16), .TIMEOUT_CYCLES(TO), .LFSR_SEED(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_address(base_address),
    .cmd_ready(cmd_ready), .write_enable(write_enable), .read_enable(read_enable),
    .user_address(user_address), .user_wdata(user_wdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_error_address(first_error_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] base;
    int            pct;
    bit            corrupt;
    bit            drop;
    bit            chk_wrap;
    bit            e_pass;
    bit            e_timeout;
    logic [15:0]   e_err;
    logic [AW-1:0] e_first;
  } vec_t;

  typedef struct {
    logic [DQ-1:0] data;
    int            due;
  } resp_t;

  int n_vec = 0;
  int n_fail = 0;

  // Memory-model state shared with the stimulus process.
  int            ready_pct = 100;
  bit            corrupt_en = 0, drop_en = 0;
  logic [AW-1:0] cur_base = '0;
  logic [DQ-1:0] exp_pat [NW];
  int            wr_cnt = 0, rd_cnt = 0, proto_err = 0, cyc = 0;
  logic [AW-1:0] first_addrs [4];
  logic [DQ-1:0] mem [logic [AW-1:0]];
  resp_t         rq [$];
  bit            prev_pending = 0;
  logic          prev_we, prev_re;
  logic [AW-1:0] prev_addr;
  logic [DQ-1:0] prev_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected write pattern for a mode, computed directly from the pattern definitions.
  task automatic build_pattern(input logic [1:0] m);
    logic [15:0] s;
    s = 16'h0001;
    for (int i = 0; i < NW; i++) begin
      case (m)
        2'd0: exp_pat[i] = 16'(i);
        2'd1: exp_pat[i] = 16'h0001 << (i % 16);
        2'd2: begin
          exp_pat[i] = s;
          s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
        end
        default: exp_pat[i] = (i % 2 == 1) ? 16'hAAAA : 16'h5555;
      endcase
    end
  endtask

  // Memory model: drives cmd_ready and read responses at the falling edge and
  // scoreboards each request that will be accepted on the next rising edge.
  initial begin
    logic [AW-1:0] ea;
    logic [DQ-1:0] d;
    resp_t r;
    cmd_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_pending && (write_enable !== prev_we || read_enable !== prev_re ||
          user_address !== prev_addr || (prev_we && user_wdata !== prev_data)))
        proto_err++;
      if (write_enable && read_enable) proto_err++;
      rd_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        rd_valid = 1'b1;
        rd_data  = r.data;
      end
      cmd_ready = ($urandom_range(99) < ready_pct);
      if (write_enable && cmd_ready) begin
        ea = cur_base + AW'(wr_cnt);
        if (wr_cnt >= NW || rd_cnt != 0) proto_err++;
        else if (user_address !== ea || user_wdata !== exp_pat[wr_cnt]) proto_err++;
        mem[user_address] = user_wdata;
        if (wr_cnt < 4) first_addrs[wr_cnt] = user_address;
        wr_cnt++;
      end
      if (read_enable && cmd_ready) begin
        ea = cur_base + AW'(rd_cnt);
        if (wr_cnt != NW || user_address !== ea) proto_err++;
        d = mem.exists(user_address) ? mem[user_address] : '0;
        if (corrupt_en && (user_address == cur_base + AW'(10) || user_address == cur_base + AW'(20)))
          d = d ^ 16'h0008;
        if (!(drop_en && rd_cnt == NW - 1)) rq.push_back('{data: d, due: cyc + 5});
        rd_cnt++;
      end
      prev_pending = (write_enable || read_enable) && !cmd_ready;
      prev_we   = write_enable;
      prev_re   = read_enable;
      prev_addr = user_address;
      prev_data = user_wdata;
    end
  end

  task automatic setup_model(input vec_t v);
    cur_base   = v.base;
    ready_pct  = v.pct;
    corrupt_en = v.corrupt;
    drop_en    = v.drop;
    build_pattern(v.mode);
    wr_cnt = 0;
    rd_cnt = 0;
    proto_err = 0;
    prev_pending = 0;
    mem.delete();
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    mode = v.mode;
    base_address = v.base;
    @(negedge clk);
    start = 1'b0;
    mode = ~v.mode;
    base_address = ~v.base;
  endtask

  task automatic run_test(input vec_t v, input int idx);
    setup_model(v);
    pulse_start(v);
    check($sformatf("v%0d start_busy_done", idx), {126'd0, busy, done}, {126'd0, 2'b10});
    for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
    check($sformatf("v%0d done", idx), {127'd0, done}, 128'd1);
    check($sformatf("v%0d busy_end", idx), {127'd0, busy}, 128'd0);
    check($sformatf("v%0d pass", idx), {127'd0, pass}, {127'd0, v.e_pass});
    check($sformatf("v%0d timeout", idx), {127'd0, timeout}, {127'd0, v.e_timeout});
    check($sformatf("v%0d error_count", idx), {112'd0, error_count}, {112'd0, v.e_err});
    check($sformatf("v%0d first_error_address", idx), {110'd0, first_error_address}, {110'd0, v.e_first});
    check($sformatf("v%0d protocol_errors", idx), 128'(proto_err), 128'd0);
    check($sformatf("v%0d writes", idx), 128'(wr_cnt), 128'(NW));
    check($sformatf("v%0d reads", idx), 128'(rd_cnt), 128'(NW));
    if (v.chk_wrap)
      check($sformatf("v%0d wrap_addrs", idx),
            {56'd0, first_addrs[0], first_addrs[1], first_addrs[2], first_addrs[3]},
            {56'd0, 18'h3FFFF, 18'h00000, 18'h00001, 18'h00002});
    repeat (10) @(negedge clk);
  endtask

  function automatic logic [127:0] all_outputs();
    return {54'd0, write_enable, read_enable, busy, done, pass, timeout,
            user_address, user_wdata, error_count, first_error_address};
  endfunction

  vec_t vecs [8];

  initial begin
    int snap_wr, snap_rd;
    vecs[0] = '{2'd0, 18'h00000, 100, 0, 0, 0, 1, 0, 16'd0, 18'h00000};
    vecs[1] = '{2'd1, 18'h00100,  50, 0, 0, 0, 1, 0, 16'd0, 18'h00000};
    vecs[2] = '{2'd2, 18'h12345,  50, 0, 0, 0, 1, 0, 16'd0, 18'h00000};
    vecs[3] = '{2'd3, 18'h00020,  50, 0, 0, 0, 1, 0, 16'd0, 18'h00000};
    vecs[4] = '{2'd3, 18'h01000, 100, 1, 0, 0, 0, 0, 16'd2, 18'h0100A};
    vecs[5] = '{2'd0, 18'h3FFFF, 100, 0, 0, 1, 1, 0, 16'd0, 18'h00000};
    vecs[6] = '{2'd2, 18'h00500,  50, 0, 1, 0, 0, 1, 16'd0, 18'h00000};
    vecs[7] = '{2'd1, 18'h00500, 100, 0, 0, 0, 1, 0, 16'd0, 18'h00000};

    reset = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    base_address = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 128'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outputs(), 128'd0);

    for (int i = 0; i < 8; i++) run_test(vecs[i], i);

    // Reset while reads are in flight: everything drops to zero and no more requests.
    setup_model(vecs[0]);
    pulse_start(vecs[0]);
    for (int i = 0; i < 2000 && rd_cnt < 3; i++) @(negedge clk);
    check("mid_read_reached", {127'd0, read_enable}, 128'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_read_reset_outputs", all_outputs(), 128'd0);
    snap_wr = wr_cnt;
    snap_rd = rd_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_no_requests", 128'({wr_cnt, rd_cnt}), 128'({snap_wr, snap_rd}));
    check("post_reset_idle_outputs", all_outputs(), 128'd0);
    run_test(vecs[0], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
